// File: rtl/bnn_accumulator.sv
// Accumulates signed BNN partial sums per neuron, thresholds each finished neuron
// to one activation bit and packs the bits into words handed out via valid/ready.
module bnn_accumulator #(
  parameter int PACK_W = 32,
  parameter int IDX_W  = 6   // must be wide enough to hold the value PACK_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              at_WE,
  input  logic [31:0]       ExtImmE,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_partial,
  input  logic              in_last,
  input  logic              flush_E,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PACK_W-1:0] out_word,
  output logic [IDX_W-1:0]  out_count,
  output logic              busy
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t              state_q, state_d;
  logic signed [31:0]  acc_q, acc_d;
  logic signed [31:0]  thr_q, thr_d;
  logic [PACK_W-1:0]   pack_q, pack_d, pack_upd;
  logic [PACK_W-1:0]   out_word_q, out_word_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d, idx_upd;
  logic [IDX_W-1:0]    out_count_q, out_count_d;
  logic                flush_pend_q, flush_pend_d;

  logic                accept, close_neuron, act_bit, word_full, flush_now, emit;
  logic signed [32:0]  sum_wide;
  logic signed [31:0]  sum_sat;

  assign accept       = in_valid && (state_q == FILL);
  assign close_neuron = accept && in_last;

  assign sum_wide = {acc_q[31], acc_q} + {in_partial[31], in_partial};

  // Overflow shows up as the two top bits of the 33-bit sum disagreeing.
  always_comb begin
    if (sum_wide[32] != sum_wide[31]) begin
      sum_sat = sum_wide[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    end else begin
      sum_sat = sum_wide[31:0];
    end
  end

  assign act_bit   = (sum_sat >= thr_q);
  assign idx_upd   = close_neuron ? (bit_idx_q + IDX_W'(1)) : bit_idx_q;
  assign word_full = close_neuron && (bit_idx_q == IDX_W'(PACK_W - 1));
  // A beat in the flush cycle is applied first, so idx_upd already counts it.
  assign flush_now = (state_q == FILL) && (flush_pend_q || flush_E);
  assign emit      = word_full || (flush_now && (idx_upd != '0));

  for (genvar gi = 0; gi < PACK_W; gi++) begin : g_pack
    assign pack_upd[gi] = (close_neuron && (bit_idx_q == IDX_W'(gi))) ? act_bit : pack_q[gi];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (emit)      state_d = HOLD;
      HOLD:    if (out_ready) state_d = FILL;
      default:                state_d = FILL;
    endcase
  end

  always_comb begin
    out_valid = (state_q == HOLD);
    in_ready  = (state_q == FILL);
    out_word  = out_word_q;
    out_count = out_count_q;
    busy      = (acc_q != '0) || (bit_idx_q != '0) || (state_q == HOLD) || flush_pend_q;
  end

  always_comb begin
    acc_d        = acc_q;
    thr_d        = at_WE ? ExtImmE : thr_q;
    pack_d       = pack_upd;
    bit_idx_d    = idx_upd;
    out_word_d   = out_word_q;
    out_count_d  = out_count_q;
    flush_pend_d = flush_pend_q || flush_E;

    if (accept) begin
      acc_d = in_last ? '0 : sum_sat;
    end
    if (emit) begin
      out_word_d  = pack_upd;
      out_count_d = idx_upd;
      pack_d      = '0;
      bit_idx_d   = '0;
    end
    // A full word also consumes a pending flush: nothing is left to emit.
    if (flush_now) begin
      flush_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q        <= '0;
      thr_q        <= '0;
      pack_q       <= '0;
      bit_idx_q    <= '0;
      out_word_q   <= '0;
      out_count_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      thr_q        <= thr_d;
      pack_q       <= pack_d;
      bit_idx_q    <= bit_idx_d;
      out_word_q   <= out_word_d;
      out_count_q  <= out_count_d;
      flush_pend_q <= flush_pend_d;
    end
  end

endmodule

// File: tb/tb_bnn_accumulator.sv
// Directed and randomized bench for bnn_accumulator; a bit-queue model of the
// neuron/threshold/pack rules predicts every emitted word.
module tb_bnn_accumulator;
  localparam int PACK_W = 32;
  localparam int IDX_W  = 6;
  localparam longint SMAX = 64'sh0000_0000_7FFF_FFFF;
  localparam longint SMIN = -64'sh0000_0000_8000_0000;

  logic              clk, reset, at_WE, in_valid, in_ready, in_last, flush_E;
  logic              out_valid, out_ready, busy;
  logic [31:0]       ExtImmE, in_partial;
  logic [PACK_W-1:0] out_word;
  logic [IDX_W-1:0]  out_count;

  int checks = 0;
  int errors = 0;

  int          model_acc;
  int          model_thr;
  bit          model_bits[$];
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];

  bnn_accumulator #(.PACK_W(PACK_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .at_WE(at_WE), .ExtImmE(ExtImmE),
    .in_valid(in_valid), .in_ready(in_ready), .in_partial(in_partial), .in_last(in_last),
    .flush_E(flush_E), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_count(out_count), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      obs_q.push_back(64'({out_count, out_word}));
      $display("xfer: count=%0d word=%h", out_count, out_word);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic void model_emit();
    logic [PACK_W-1:0] w;
    if (model_bits.size() == 0) return;
    w = '0;
    foreach (model_bits[i]) w[i] = model_bits[i];
    exp_q.push_back(64'({IDX_W'(model_bits.size()), w}));
    model_bits.delete();
  endfunction

  function automatic void model_beat(input logic [31:0] p, input logic last);
    longint s;
    s = longint'(model_acc) + longint'($signed(p));
    if (s > SMAX) s = SMAX;
    if (s < SMIN) s = SMIN;
    if (last) begin
      model_bits.push_back(s >= longint'(model_thr));
      model_acc = 0;
      if (model_bits.size() == PACK_W) model_emit();
    end else begin
      model_acc = int'(s);
    end
  endfunction

  function automatic logic [31:0] rnd_partial();
    int v;
    if ($urandom_range(3) == 0) return $urandom;
    v = int'($urandom_range(200)) - 100;
    return v;
  endfunction

  task automatic beat(input logic [31:0] p, input logic last, input logic fl,
                      input logic we, input logic [31:0] wd);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) begin
      chk("in_ready_wait", 64'(in_ready), 64'(1));
      return;
    end
    in_valid = 1'b1; in_partial = p; in_last = last;
    flush_E = fl; at_WE = we; ExtImmE = wd;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; flush_E = 1'b0; at_WE = 1'b0;
    model_beat(p, last);
    if (fl) model_emit();
    if (we) model_thr = int'(wd);
  endtask

  task automatic write_thr(input logic [31:0] v);
    at_WE = 1'b1; ExtImmE = v;
    @(posedge clk); #1;
    at_WE = 1'b0;
    model_thr = int'(v);
  endtask

  task automatic do_flush();
    flush_E = 1'b1;
    @(posedge clk); #1;
    flush_E = 1'b0;
    model_emit();
  endtask

  task automatic drain_check(input string tag);
    int guard;
    logic [63:0] o, e;
    guard = 0;
    while (obs_q.size() < exp_q.size() && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_nwords"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_word"}, o, e);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [63:0] e;
    logic [31:0] p;

    reset = 1'b0; at_WE = 1'b0; ExtImmE = '0; in_valid = 1'b0; in_partial = '0;
    in_last = 1'b0; flush_E = 1'b0; out_ready = 1'b1;
    model_acc = 0; model_thr = 0;

    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_word", 64'(out_word), 64'(0));
    chk("rst_out_count", 64'(out_count), 64'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 64'(in_ready), 64'(1));

    // Single-chunk neurons +3, -1, 0 repeated; full word one cycle after 32nd beat
    for (int i = 0; i < PACK_W; i++) begin
      case (i % 3)
        0: beat(32'd3, 1'b1, 1'b0, 1'b0, '0);
        1: beat(-32'sd1, 1'b1, 1'b0, 1'b0, '0);
        default: beat(32'd0, 1'b1, 1'b0, 1'b0, '0);
      endcase
    end
    e = exp_q[$];
    chk("full_out_valid", 64'(out_valid), 64'(1));
    chk("full_out_count", 64'(out_count), 64'(PACK_W));
    chk("full_out_word", 64'(out_word), 64'(e[PACK_W-1:0]));
    drain_check("full");

    // Multi-chunk neurons and threshold timing
    beat(32'd5, 1'b0, 1'b0, 1'b0, '0);
    beat(-32'sd4, 1'b0, 1'b0, 1'b0, '0);
    beat(-32'sd2, 1'b1, 1'b0, 1'b0, '0);
    write_thr(-32'sd1);
    beat(32'd5, 1'b0, 1'b0, 1'b0, '0);
    beat(-32'sd4, 1'b0, 1'b0, 1'b0, '0);
    beat(-32'sd2, 1'b1, 1'b0, 1'b0, '0);
    beat(32'd5, 1'b0, 1'b0, 1'b0, '0);
    beat(-32'sd4, 1'b0, 1'b0, 1'b0, '0);
    beat(-32'sd2, 1'b1, 1'b0, 1'b1, 32'd100);
    write_thr(32'd0);
    do_flush();
    chk("multi_out_count", 64'(out_count), 64'(3));
    chk("multi_out_word", 64'(out_word), 64'(6));
    drain_check("multi");

    // Saturation at both rails
    write_thr(32'h7FFF_FFFF);
    beat(32'h7FFF_FFF0, 1'b0, 1'b0, 1'b0, '0);
    beat(32'h0000_0100, 1'b0, 1'b0, 1'b0, '0);
    beat(32'd0, 1'b1, 1'b0, 1'b0, '0);
    write_thr(32'h8000_0001);
    beat(32'h8000_0010, 1'b0, 1'b0, 1'b0, '0);
    beat(32'hFFFF_FF00, 1'b0, 1'b0, 1'b0, '0);
    beat(32'd0, 1'b1, 1'b0, 1'b0, '0);
    write_thr(32'h8000_0000);
    beat(32'h8000_0010, 1'b0, 1'b0, 1'b0, '0);
    beat(32'hFFFF_FF00, 1'b0, 1'b0, 1'b0, '0);
    beat(32'd0, 1'b1, 1'b0, 1'b0, '0);
    write_thr(32'd0);
    do_flush();
    chk("sat_out_count", 64'(out_count), 64'(3));
    chk("sat_out_word", 64'(out_word), 64'(5));
    drain_check("sat");

    // Flush of a partial word, flush coincident with a beat, flush with nothing packed
    for (int r = 0; r < 2; r++) begin
      beat(32'd1, 1'b1, 1'b0, 1'b0, '0);
      beat(32'd2, 1'b1, 1'b0, 1'b0, '0);
      beat(-32'sd3, 1'b1, 1'b0, 1'b0, '0);
      beat(32'd4, 1'b1, 1'b0, 1'b0, '0);
      beat(-32'sd5, 1'b1, 1'b0, 1'b0, '0);
      if (r == 0) begin
        do_flush();
        chk("flush5_out_valid", 64'(out_valid), 64'(1));
        chk("flush5_out_word", 64'(out_word), 64'(32'h0000_000B));
        chk("flush5_out_count", 64'(out_count), 64'(5));
        drain_check("flush5");
      end else begin
        beat(32'd7, 1'b1, 1'b1, 1'b0, '0);
        chk("flush6_out_count", 64'(out_count), 64'(6));
        chk("flush6_out_word", 64'(out_word), 64'(32'h0000_002B));
        drain_check("flush6");
      end
    end
    do_flush();
    chk("flush0_out_valid", 64'(out_valid), 64'(0));
    chk("flush0_busy", 64'(busy), 64'(0));
    drain_check("flush0");

    // Backpressure: word held, producer holds a beat, one handshake then the beat lands
    out_ready = 1'b0;
    for (int i = 0; i < PACK_W; i++) beat(rnd_partial(), 1'b1, 1'b0, 1'b0, '0);
    chk("bp_out_valid", 64'(out_valid), 64'(1));
    e = exp_q[$];
    in_valid = 1'b1; in_partial = 32'd9; in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_word_stable", 64'(out_word), 64'(e[PACK_W-1:0]));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released_valid", 64'(out_valid), 64'(0));
    chk("bp_released_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    model_beat(32'd9, 1'b1);
    do_flush();
    drain_check("bp");

    // Flush requested while a word is held: serviced in the first FILL cycle
    out_ready = 1'b0;
    for (int i = 0; i < PACK_W; i++) beat(rnd_partial(), 1'b1, 1'b0, 1'b0, '0);
    do_flush();
    chk("hflush_busy", 64'(busy), 64'(1));
    in_valid = 1'b1; in_partial = 32'd7; in_last = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hflush_drained", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    model_beat(32'd7, 1'b1);
    model_emit();
    chk("hflush_out_valid", 64'(out_valid), 64'(1));
    chk("hflush_out_count", 64'(out_count), 64'(1));
    drain_check("hflush");

    // Randomized beats, chunk boundaries, flushes and threshold writes
    for (int i = 0; i < 300; i++) begin
      p = $urandom_range(40) - 20;
      beat(rnd_partial(), ($urandom_range(2) == 0), ($urandom_range(15) == 0),
           ($urandom_range(9) == 0), p);
    end
    do_flush();
    drain_check("rand");

    // Reset in the middle of a word with an accumulator in progress
    for (int i = 0; i < 7; i++) beat(rnd_partial(), 1'b1, 1'b0, 1'b0, '0);
    beat(32'd12, 1'b0, 1'b0, 1'b0, '0);
    chk("mid_busy", 64'(busy), 64'(1));
    reset = 1'b0;
    #2;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    model_bits.delete();
    model_acc = 0;
    model_thr = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_in_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < PACK_W; i++) beat(rnd_partial(), 1'b1, 1'b0, 1'b0, '0);
    chk("mid_clean_count", 64'(out_count), 64'(PACK_W));
    drain_check("mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
